serial_2com_conv: RTL and testbench
===================================

# serial_2com_conv

Bit-serial two's-complement converter. Accepts a WIDTH-bit binary word over a valid/ready handshake and computes its two's complement LSB-first, one bit per clock, using the copy-until-first-one rule. It returns the parallel result over a second valid/ready handshake and exposes the serial bit stream. It is the sequential counterpart of the combinational 4-bit two's-complement stage, sized for area-constrained paths that can tolerate WIDTH-cycle latency.

## Interface
Parameters:
- WIDTH, 4, data word width in bits (≥2)

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream word available
- in_ready  output  1  block can accept a word (high only in IDLE)
- B  input  WIDTH  binary input word, sampled on accept
- out_valid  output  1  complement_2 holds a finished result
- out_ready  input  1  downstream accepts result
- complement_2  output  WIDTH  two's complement of accepted B (mod 2^WIDTH)
- ser_bit  output  1  current serial result bit, LSB first
- ser_valid  output  1  ser_bit valid (high during SHIFT)

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: load shreg←B, clear seen_one, clear bit counter, clear result register, go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - b=shreg[0]; ser_bit = seen_one ? ~b : b; ser_valid=1.
  - At the clock edge: seen_one←seen_one|b; shreg shifts right; result shifts right with ser_bit entering at the MSB; counter increments.
  - After the WIDTH-th shift, go to DONE.
- DONE: out_valid=1, complement_2 stable. On out_ready go to IDLE. in_ready=0, so there is no overlap of output and input handshakes.
- Arithmetic is modulo 2^WIDTH:
  - 0 → 0.
  - Most-negative value (1 followed by zeros) → itself.
- in_valid while not in IDLE is ignored. B changing after accept has no effect.
- out_ready outside DONE is ignored.

## Timing
- Reset values: state=IDLE, in_ready=1 (IDLE output), out_valid=0, complement_2=0, ser_bit=0, ser_valid=0, internal shreg/seen_one/counter=0.
- Accept at edge k. SHIFT occupies the cycles after edges k..k+WIDTH-1. out_valid rises after edge k+WIDTH.
- Latency is WIDTH+1 cycles from the accept edge to the first cycle out_valid is sampled high.
- Minimum period is WIDTH+2 cycles per word when out_ready is tied high: accept, WIDTH shifts, DONE for 1 cycle, back in IDLE.
- complement_2 updates only during SHIFT. It holds its value through DONE and IDLE until the next accept clears it.
- rst asserted in any state, including mid-SHIFT or in DONE with out_valid high: at the next edge, return to reset values. The in-flight word is discarded and no out_valid pulse is issued.
- rst has priority over every handshake in the same cycle.

## Configuration
- SERIAL_2COM_OVF_EN defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf is latched on accept as (B == 1<<(WIDTH-1)) and is valid while out_valid=1.
  - ovf is cleared on the next accept and on rst.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

## Structure
- Package serial_2com_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the counter-width constant, $clog2(WIDTH+1).
- One sub-module, serial_2com_cell: the 1-bit copy/invert cell.
  - Inputs b and seen_one; outputs ser_bit and the next seen_one.
  - Purely combinational. The seen_one register stays in the parent.
- Parent holds the FSM, shreg, result register and counter.

## Test plan
- Reset, then WIDTH=4, B=0101, out_ready=1 → ser_bit sequence 1,1,0,1 (LSB first). complement_2=1011 with out_valid high exactly 5 cycles after accept; ovf=0.
- Sweep B=0..15, one word at a time → complement_2 equals (16−B)%16 for each word: 0→0000, 1→1111, 8→1000 (ovf=1 when macro defined), 15→0001.
- Back-pressure: B=0011, out_ready=0 for 6 cycles after DONE → complement_2=1101 and out_valid stay stable, and in_ready stays 0. A new in_valid with B=0001 during the hold is not accepted.
- Reset mid-SHIFT: accept B=0110, assert rst for 1 cycle after 2 shifts → all outputs at reset values next cycle. No out_valid pulse; a following B=0010 yields 1110.
- Back-to-back: in_valid held high with B=0001 then 0111, out_ready=1 → results 1111 then 1001, accepts spaced exactly 6 cycles apart.
- Parameter check, WIDTH=8: B=0x80 → 0x80 with ovf=1; B=0x01 → 0xFF; out_valid rises 9 cycles after accept.

Source files
------------

// File: rtl/serial_2com_pkg.sv
// Shared types and sizing helpers for the bit-serial two's-complement converter.
package serial_2com_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter must reach WIDTH, so it needs clog2(WIDTH+1) bits
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_2com_conv_cell.sv
// Copy/invert cell: pass bits through until the first one, invert afterwards.
module serial_2com_cell (
  input  logic b,
  input  logic seen_one,
  output logic ser_bit,
  output logic seen_one_nxt
);

  assign ser_bit      = seen_one ^ b;
  assign seen_one_nxt = seen_one | b;

endmodule

// File: rtl/serial_2com_conv.sv
// Bit-serial two's-complement converter, LSB first, one bit per clock.
// Optional overflow flag output enabled by defining SERIAL_2COM_OVF_EN.
module serial_2com_conv
  import serial_2com_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] complement_2,
`ifdef SERIAL_2COM_OVF_EN
  output logic             ovf,
`endif
  output logic             ser_bit,
  output logic             ser_valid
);

  localparam int unsigned CW = cnt_width(WIDTH);
`ifdef SERIAL_2COM_OVF_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_t          state;
  logic [WIDTH-1:0] shreg;
  logic             seen_one;
  logic [CW-1:0]    cnt;
  logic             cur_bit;
  logic             seen_nxt;

  serial_2com_cell u_cell (
    .b            (shreg[0]),
    .seen_one     (seen_one),
    .ser_bit      (cur_bit),
    .seen_one_nxt (seen_nxt)
  );

  // ser_valid is only high in SHIFT, so this gate gives ser_bit=0 elsewhere
  assign ser_bit = ser_valid & cur_bit;

  // FSM, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      ser_valid    <= 1'b0;
      shreg        <= '0;
      seen_one     <= 1'b0;
      cnt          <= '0;
      complement_2 <= '0;
`ifdef SERIAL_2COM_OVF_EN
      ovf          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg        <= B;
            seen_one     <= 1'b0;
            cnt          <= '0;
            complement_2 <= '0;
            in_ready     <= 1'b0;
            ser_valid    <= 1'b1;
            state        <= SHIFT;
`ifdef SERIAL_2COM_OVF_EN
            ovf          <= (B == MIN_NEG);
`endif
          end
        end
        SHIFT: begin
          shreg        <= shreg >> 1;
          seen_one     <= seen_nxt;
          complement_2 <= {cur_bit, complement_2[WIDTH-1:1]};
          cnt          <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            ser_valid <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          ser_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_2com_conv.sv
// Self-checking bench for serial_2com_conv (WIDTH=4); reference is arithmetic negation mod 2^W.
module tb_serial_2com_conv;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] complement_2;
  logic         ser_bit;
  logic         ser_valid;
`ifdef SERIAL_2COM_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_2com_conv #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .B            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .complement_2 (complement_2),
`ifdef SERIAL_2COM_OVF_EN
    .ovf          (ovf),
`endif
    .ser_bit      (ser_bit),
    .ser_valid    (ser_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_neg(input int unsigned v);
    int unsigned m;
    m = 2 ** W;
    return W'((m - (v % m)) % m);
  endfunction

  // One complete word: accept, W serial bits, DONE with optional hold, back to IDLE
  task automatic run_word(input logic [W-1:0] bv, input int hold, input bit poke);
    logic [W-1:0] e;
    e = ref_neg(int'(bv));
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    b         = bv;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    b        = W'($urandom);
    for (int i = 0; i < int'(W); i++) begin
      chk("ser_valid", ser_valid, 1);
      chk("ser_bit", ser_bit, e[i]);
      chk("out_valid_shift", out_valid, 0);
      chk("in_ready_shift", in_ready, 0);
      @(negedge clk);
    end
    chk("out_valid_done", out_valid, 1);
    chk("result", complement_2, e);
    chk("ser_valid_done", ser_valid, 0);
`ifdef SERIAL_2COM_OVF_EN
    chk("ovf", ovf, (int'(bv) == 2 ** (W - 1)));
`endif
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        in_valid = 1'b1;
        b        = W'(1);
      end
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", complement_2, e);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_result_held", complement_2, e);
  endtask

  initial begin
    int cyc;
    int acc0;
    int acc1;
    logic [W-1:0] res[$];

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    b         = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", complement_2, 0);
    chk("rst_ser_bit", ser_bit, 0);
    chk("rst_ser_valid", ser_valid, 0);
`ifdef SERIAL_2COM_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Directed 0101 -> 1011, serial 1,1,0,1
    run_word(W'(5), 0, 1'b0);

    // Full sweep of input values
    for (int v = 0; v < 2 ** W; v++) run_word(W'(v), 0, 1'b0);

    // Back-pressure with an ignored in_valid during the hold
    run_word(W'(3), 6, 1'b1);
    chk("bp_no_accept_ser_valid", ser_valid, 0);

    // Reset in the middle of SHIFT
    in_valid = 1'b1;
    b        = W'(6);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_ser_valid", ser_valid, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_result", complement_2, 0);
    chk("mid_rst_ser_valid", ser_valid, 0);
    chk("mid_rst_ser_bit", ser_bit, 0);
    for (int i = 0; i < int'(W) + 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_pulse", out_valid, 0);
    end
    run_word(W'(2), 0, 1'b0);

    // Back-to-back with in_valid held high
    in_valid  = 1'b1;
    b         = W'(1);
    out_ready = 1'b1;
    cyc  = 0;
    acc0 = -1;
    acc1 = -1;
    while (res.size() < 2 && cyc < 60) begin
      if (in_ready) begin
        if (acc0 < 0) acc0 = cyc;
        else if (acc1 < 0) acc1 = cyc;
      end
      if (out_valid) res.push_back(complement_2);
      @(negedge clk);
      cyc++;
      if (acc0 >= 0) b = W'(7);
    end
    in_valid = 1'b0;
    chk("b2b_count", res.size(), 2);
    if (res.size() >= 2) begin
      chk("b2b_res0", res[0], ref_neg(1));
      chk("b2b_res1", res[1], ref_neg(7));
    end
    chk("b2b_spacing", acc1 - acc0, W + 2);
    @(negedge clk);
    chk("b2b_idle", in_ready, 1);

    // Randomised words with random hold
    for (int n = 0; n < 25; n++) begin
      run_word(W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
